wallace_mult_pipe: RTL and testbench

//  Parametrised, pipelined Wallace-tree multiplier. Successor to the 4x4 combinational tree.
//  - Per-transaction signed/unsigned mode on each operand independently.
//  - Configurable operand widths and number of internal tree register levels.
//  - valid/ready handshake with full backpressure. Used as the multiply engine in datapath blocks.

---
 rtl/wallace_mult_pipe.sv | 182 ++++++++++++++++++
 tb/tb_wallace_mult_pipe.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/wallace_mult_pipe.sv
// Pipelined Wallace-tree multiplier with per-operand signed/unsigned mode and valid/ready flow control.
// Optional running accumulator on the output handshake is enabled by defining WTM_ACC_EN.
module wallace_mult_pipe #(
  parameter int WIDTH_A     = 8,
  parameter int WIDTH_B     = 8,
  parameter int PIPE_STAGES = 2,
  parameter int ACC_WIDTH   = WIDTH_A + WIDTH_B + 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH_A-1:0]         a,
  input  logic [WIDTH_B-1:0]         b,
  input  logic                       a_signed,
  input  logic                       b_signed,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH_A+WIDTH_B-1:0] product
`ifdef WTM_ACC_EN
  ,
  input  logic                       acc_clr,
  output logic [ACC_WIDTH-1:0]       acc_out
`endif
);

  localparam int W = WIDTH_A + WIDTH_B;
  typedef logic [W-1:0][W-1:0] rows_t;

  if (WIDTH_A < 2 || WIDTH_B < 2 || PIPE_STAGES < 1 || PIPE_STAGES > 4 || ACC_WIDTH <= W) begin : g_bad_param
    $error("wallace_mult_pipe: unsupported parameter combination");
  end

  function automatic int next_rows(input int n);
    return 2 * (n / 3) + n % 3;
  endfunction

  function automatic int rows_after(input int l);
    int n = W;
    for (int i = 0; i < l; i++) n = next_rows(n);
    return n;
  endfunction

  function automatic int count_layers();
    int n = W;
    int c = 0;
    while (n > 2) begin
      n = next_rows(n);
      c++;
    end
    return c;
  endfunction

  localparam int LAYERS = count_layers();

  // One layer of full adders: each group of three rows becomes a sum row and a shifted carry row.
  function automatic rows_t csa_layer(input rows_t r, input int n);
    rows_t o = '0;
    for (int t = 0; t < W / 3; t++) begin
      if (3 * t + 2 < n) begin
        o[2*t]   = r[3*t] ^ r[3*t+1] ^ r[3*t+2];
        o[2*t+1] = ((r[3*t] & r[3*t+1]) | (r[3*t] & r[3*t+2]) | (r[3*t+1] & r[3*t+2])) << 1;
      end
    end
    for (int j = 0; j < 2; j++)
      if (j < n % 3) o[2*(n/3)+j] = r[3*(n/3)+j];
    return o;
  endfunction

  // Tree layers are spread evenly over the register levels; a level may hold zero layers.
  function automatic rows_t reduce_stage(input rows_t r, input int s);
    rows_t x = r;
    for (int l = s * LAYERS / PIPE_STAGES; l < (s + 1) * LAYERS / PIPE_STAGES; l++)
      x = csa_layer(x, rows_after(l));
    return x;
  endfunction

  function automatic logic [W-1:0] ext_a(input logic [WIDTH_A-1:0] v, input logic sg);
    return {{(W-WIDTH_A){sg & v[WIDTH_A-1]}}, v};
  endfunction

  function automatic logic [W-1:0] ext_b(input logic [WIDTH_B-1:0] v, input logic sg);
    return {{(W-WIDTH_B){sg & v[WIDTH_B-1]}}, v};
  endfunction

  function automatic logic [W-1:0] final_cpa(input rows_t r);
    return r[0] + r[1];
  endfunction

  logic                   en;
  logic                   vld_p0;
  logic [WIDTH_A-1:0]     a_p0;
  logic [WIDTH_B-1:0]     b_p0;
  logic                   as_p0, bs_p0;
  logic [W-1:0]           a_ext_p0, b_ext_p0;
  rows_t                  pp_p0;
  rows_t                  rows_p1 [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] vld_p1;
  logic [W-1:0]           product_p2;
  logic                   vld_p2;

  assign en        = !vld_p2 | out_ready;
  assign in_ready  = en;
  assign out_valid = vld_p2;
  assign product   = product_p2;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= '0;
      vld_p2 <= 1'b0;
    end else if (en) begin
      vld_p0    <= in_valid;
      vld_p1[0] <= vld_p0;
      for (int s = 1; s < PIPE_STAGES; s++) vld_p1[s] <= vld_p1[s-1];
      vld_p2    <= vld_p1[PIPE_STAGES-1];
    end
  end

  // p0: input capture, operands keep their mode bits
  always_ff @(posedge clk) begin
    if (en) begin
      a_p0  <= a;
      b_p0  <= b;
      as_p0 <= a_signed;
      bs_p0 <= b_signed;
    end
  end

  assign a_ext_p0 = ext_a(a_p0, as_p0);
  assign b_ext_p0 = ext_b(b_p0, bs_p0);

  always_comb begin
    pp_p0 = '0;
    for (int i = 0; i < W; i++) pp_p0[i] = b_ext_p0[i] ? (a_ext_p0 << i) : '0;
  end

  // p1: reduction tree register levels
  always_ff @(posedge clk) begin
    if (en) begin
      rows_p1[0] <= reduce_stage(pp_p0, 0);
      for (int s = 1; s < PIPE_STAGES; s++) rows_p1[s] <= reduce_stage(rows_p1[s-1], s);
    end
  end

  // p2: carry-propagate adder output register
  always_ff @(posedge clk) begin
    if (rst) product_p2 <= '0;
    else if (en && vld_p1[PIPE_STAGES-1]) product_p2 <= final_cpa(rows_p1[PIPE_STAGES-1]);
  end

`ifdef WTM_ACC_EN
  logic [PIPE_STAGES-1:0]        sgn_p1;
  logic                          sgn_p2;
  logic                          hs_p2;
  logic signed [ACC_WIDTH-1:0]   acc_p3;

  function automatic logic signed [ACC_WIDTH-1:0] acc_ext(input logic [W-1:0] p, input logic sg);
    return {{(ACC_WIDTH-W){sg & p[W-1]}}, p};
  endfunction

  always_ff @(posedge clk) begin
    if (en) begin
      sgn_p1[0] <= as_p0 | bs_p0;
      for (int s = 1; s < PIPE_STAGES; s++) sgn_p1[s] <= sgn_p1[s-1];
      if (vld_p1[PIPE_STAGES-1]) sgn_p2 <= sgn_p1[PIPE_STAGES-1];
    end
  end

  assign hs_p2 = vld_p2 & out_ready;

  // p3: accumulator, clear takes priority over the running sum
  always_ff @(posedge clk) begin
    if (rst) acc_p3 <= '0;
    else if (acc_clr) acc_p3 <= hs_p2 ? acc_ext(product_p2, sgn_p2) : '0;
    else if (hs_p2) acc_p3 <= acc_p3 + acc_ext(product_p2, sgn_p2);
  end

  assign acc_out = acc_p3;
`endif

endmodule

// File: tb/tb_wallace_mult_pipe.sv
// Scoreboard bench for wallace_mult_pipe (8x8, two tree levels): directed vectors with hand-computed products.
// Accumulator cases run when WTM_ACC_EN is defined.
module tb_wallace_mult_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic        a_signed = 1'b0;
  logic        b_signed = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] product;
`ifdef WTM_ACC_EN
  logic        acc_clr = 1'b0;
  logic [23:0] acc_out;
`endif

  wallace_mult_pipe #(.WIDTH_A(8), .WIDTH_B(8), .PIPE_STAGES(2), .ACC_WIDTH(24)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .a_signed(a_signed), .b_signed(b_signed),
    .out_valid(out_valid), .out_ready(out_ready), .product(product)
`ifdef WTM_ACC_EN
    , .acc_clr(acc_clr), .acc_out(acc_out)
`endif
  );

  typedef struct {
    logic [15:0] prod;
    int          acyc;
    bit          lat;
    bit          clr;
    bit          cacc;
    logic [23:0] eacc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int stall_lo = -1;
  int stall_hi = -1;
  int issued = 0;
  int rcvd = 0;

  // a, b, a_signed, b_signed, expected product (hand-computed)
  logic [7:0]  tva [16] = '{8'h03, 8'hFE, 8'h07, 8'h00, 8'hFF, 8'h7F, 8'h80, 8'h80,
                            8'hFF, 8'hFF, 8'h10, 8'h0A, 8'h80, 8'h55, 8'hAA, 8'h01};
  logic [7:0]  tvb [16] = '{8'h04, 8'h05, 8'h07, 8'hFF, 8'h00, 8'h7F, 8'h7F, 8'h80,
                            8'hFF, 8'hFF, 8'h10, 8'hF6, 8'h80, 8'hAA, 8'h55, 8'h80};
  bit          tsa [16] = '{0, 1, 0, 1, 1, 1, 1, 0, 0, 1, 0, 1, 0, 0, 1, 1};
  bit          tsb [16] = '{0, 1, 0, 1, 0, 1, 1, 1, 1, 1, 0, 1, 0, 0, 1, 1};
  logic [15:0] tp  [16] = '{16'h000C, 16'hFFF6, 16'h0031, 16'h0000, 16'h0000, 16'h3F01, 16'hC080, 16'hC000,
                            16'hFF01, 16'h0001, 16'h0100, 16'hFF9C, 16'h4000, 16'h3872, 16'hE372, 16'hFF80};

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    out_ready = !(cycle >= stall_lo && cycle < stall_hi);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      step();
      in_valid = 1'b0;
    end
  endtask

  task automatic send(input logic [7:0] va, input logic [7:0] vb, input bit sa, input bit sbv,
                      input logic [15:0] p, input bit lat, input bit clr, input bit cacc,
                      input logic [23:0] eacc);
    int n = 0;
    exp_t e;
    step();
    a = va; b = vb; a_signed = sa; b_signed = sbv; in_valid = 1'b1;
    #1;
    while (!in_ready && n < 50) begin
      step();
      #1;
      n++;
    end
    chk("accept_in_ready", 32'(in_ready), 32'd1);
    e.prod = p; e.acyc = cycle; e.lat = lat; e.clr = clr; e.cacc = cacc; e.eacc = eacc;
    sb.push_back(e);
    issued++;
  endtask

  // Monitor: samples mid-low-phase, pops the scoreboard on each output handshake
  exp_t        me;
  logic [15:0] prev_prod = '0;
  bit          hold_prev = 0;
`ifdef WTM_ACC_EN
  bit          acc_pend = 0;
  logic [23:0] acc_want = '0;
`endif

  always @(negedge clk) begin
    #3;
`ifdef WTM_ACC_EN
    acc_clr = 1'b0;
    if (acc_pend && !rst) chk("acc_out", 32'(acc_out), 32'(acc_want));
    acc_pend = 0;
`endif
    if (rst) begin
      hold_prev = 0;
    end else begin
      if (hold_prev) begin
        chk("hold_out_valid", 32'(out_valid), 32'd1);
        chk("hold_product", 32'(product), 32'(prev_prod));
      end
      if (out_valid && !out_ready) chk("stall_in_ready", 32'(in_ready), 32'd0);
      hold_prev = out_valid && !out_ready;
      prev_prod = product;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_out_valid", 32'(out_valid), 32'd0);
        end else begin
          me = sb.pop_front();
          rcvd++;
          chk("product", 32'(product), 32'(me.prod));
          if (me.lat) chk("latency", 32'(cycle - me.acyc), 32'd4);
`ifdef WTM_ACC_EN
          if (me.clr) acc_clr = 1'b1;
          if (me.cacc) begin
            acc_pend = 1;
            acc_want = me.eacc;
          end
`endif
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_product", 32'(product), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
`ifdef WTM_ACC_EN
    chk("reset_acc_out", 32'(acc_out), 32'd0);
    send(8'd3, 8'd4, 0, 0, 16'h000C, 1, 0, 1, 24'd12);
    send(8'hFE, 8'd5, 1, 1, 16'hFFF6, 1, 0, 1, 24'd2);
    send(8'd7, 8'd7, 0, 0, 16'h0031, 1, 0, 1, 24'd51);
    idle(6);
    send(8'd1, 8'd1, 0, 0, 16'h0001, 1, 1, 1, 24'd1);
    idle(6);
`endif
    // Unsigned maximum
    send(8'hFF, 8'hFF, 0, 0, 16'hFE01, 1, 0, 0, '0);
    idle(6);
    // Signed corners
    send(8'h80, 8'h80, 1, 1, 16'h4000, 1, 0, 0, '0);
    send(8'hFF, 8'hFF, 1, 0, 16'hFF01, 1, 0, 0, '0);
    idle(6);
    // Back-to-back mixed-mode stream
    for (int i = 0; i < 16; i++) send(tva[i], tvb[i], tsa[i], tsb[i], tp[i], 1, 0, 0, '0);
    idle(8);
    // Six-cycle backpressure window in mid-stream
    stall_lo = cycle + 6;
    stall_hi = stall_lo + 6;
    for (int i = 0; i < 16; i++) send(tva[15-i], tvb[15-i], tsa[15-i], tsb[15-i], tp[15-i], 0, 0, 0, '0);
    idle(20);
    stall_lo = -1;
    stall_hi = -1;
    // Reset with three transactions in flight
    for (int i = 0; i < 3; i++) send(tva[i+5], tvb[i+5], tsa[i+5], tsb[i+5], tp[i+5], 0, 0, 0, '0);
    step();
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_product", 32'(product), 32'd0);
    issued -= sb.size();
    sb.delete();
    idle(10);
    // Post-reset sanity
    send(8'h0A, 8'hF6, 1, 1, 16'hFF9C, 1, 0, 0, '0);
    idle(2);
    n = 0;
    while (sb.size() > 0 && n < 100) begin
      step();
      n++;
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);
    chk("output_count", 32'(rcvd), 32'(issued));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
